hazard_control_unit: RTL and testbench

Pipeline hazard controller: the producer side of the `stall` / `stall_mem` / `bubble` protocol consumed by the IF/ID and ID/EX pipeline registers of the cached multi-cycle CPU. It detects three conditions and drives the control signals for each:
- load-use data hazards;
- branch/jump mispredict flushes;
- data-cache miss waits.

---
 rtl/hazard_control_unit.sv | 111 +++++++++++
 tb/tb_hazard_control_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard controller for the cached multi-cycle CPU: drives stall, bubble and stall_mem
// to the IF/ID and ID/EX registers, plus a cache-wait watchdog and a stall-cycle counter.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  id_rs,
    input  logic [1:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [1:0]  ex_dest,
    input  logic        branch_mispredict,
    input  logic        dcache_req,
    input  logic        dcache_ready,
    output logic        stall,
    output logic        bubble,
    output logic        flush_if_id,
    output logic        stall_mem,
    output logic        pc_write,
    output logic [15:0] stall_cycles,
    output logic        mem_timeout
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        pending_flush_q, pending_flush_d;
    logic [7:0]  wait_count_q, wait_count_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        load_use;

    // A cache freeze outranks everything: the pipeline registers would otherwise
    // let stall/bubble overwrite frozen state.
    always_comb begin
        load_use    = ex_mem_read &
                      ((id_uses_rs & (id_rs == ex_dest)) |
                       (id_uses_rt & (id_rt == ex_dest)));
        stall_mem   = dcache_req & ~dcache_ready;
        bubble      = ~stall_mem & (branch_mispredict | pending_flush_q);
        stall       = ~stall_mem & ~bubble & load_use;
        flush_if_id = bubble;
        pc_write    = ~stall_mem & ~stall;
    end

    always_comb begin
        state_d         = state_q;
        wait_count_d    = wait_count_q;
        mem_timeout_d   = mem_timeout_q;
        pending_flush_d = pending_flush_q;
        stall_cycles_d  = stall_cycles_q;

        // A mispredict seen during a freeze is replayed as one bubble once the freeze lifts.
        if (bubble) begin
            pending_flush_d = 1'b0;
        end else if (branch_mispredict && stall_mem) begin
            pending_flush_d = 1'b1;
        end

        if (state_q == RUN) begin
            wait_count_d = 8'd0;
            if (stall_mem) begin
                state_d = MEM_WAIT;
            end
        end else begin
            if (dcache_ready || !dcache_req) begin
                state_d      = RUN;
                wait_count_d = 8'd0;
            end else begin
                if (wait_count_q != 8'hFF) begin
                    wait_count_d = wait_count_q + 8'd1;
                end
                if (wait_count_q == TIMEOUT_LAST) begin
                    mem_timeout_d = 1'b1;
                end
            end
        end

        if ((stall || bubble || stall_mem) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RUN;
            pending_flush_q <= 1'b0;
            wait_count_q    <= 8'd0;
            stall_cycles_q  <= 16'd0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            wait_count_q    <= wait_count_d;
            stall_cycles_q  <= stall_cycles_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed checks of hazard_control_unit against a cycle-level
// behavioural model built from the protocol rules.
module tb_hazard_control_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  id_rs = '0, id_rt = '0, ex_dest = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic        branch_mispredict = 1'b0, dcache_req = 1'b0, dcache_ready = 1'b0;
    logic        stall, bubble, flush_if_id, stall_mem, pc_write, mem_timeout;
    logic [15:0] stall_cycles;

    int nChecks = 0;
    int nFails  = 0;

    // Model state: owed flush, stall-cycle total, length of the current miss run, watchdog.
    logic mPend;
    int   mCnt;
    int   mRun;
    logic mTo;

    hazard_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .branch_mispredict(branch_mispredict),
        .dcache_req(dcache_req), .dcache_ready(dcache_ready),
        .stall(stall), .bubble(bubble), .flush_if_id(flush_if_id), .stall_mem(stall_mem),
        .pc_write(pc_write), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setIdle();
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_dest = '0; branch_mispredict = 1'b0;
        dcache_req = 1'b0; dcache_ready = 1'b0;
    endtask

    // Called just after a falling edge; asserts reset mid-cycle and releases it before the next rise.
    task automatic doReset();
        #2;
        reset_n = 1'b0;
        setIdle();
        #1;
        checkOutput("rst_stall_cycles", stall_cycles, 16'd0);
        checkOutput("rst_mem_timeout", {15'd0, mem_timeout}, 16'd0);
        checkOutput("rst_pc_write", {15'd0, pc_write}, 16'd1);
        checkOutput("rst_stall", {15'd0, stall}, 16'd0);
        checkOutput("rst_bubble", {15'd0, bubble}, 16'd0);
        checkOutput("rst_flush_if_id", {15'd0, flush_if_id}, 16'd0);
        checkOutput("rst_stall_mem", {15'd0, stall_mem}, 16'd0);
        mPend = 1'b0; mCnt = 0; mRun = 0; mTo = 1'b0;
        #1;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model on the rise.
    task automatic applyStimulus(input logic [1:0] rs, input logic [1:0] rt, input logic urs,
                                 input logic urt, input logic emr, input logic [1:0] dest,
                                 input logic mis, input logic req, input logic rdy);
        logic sm, lu, bub, st, pcw;
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_read = emr; ex_dest = dest; branch_mispredict = mis;
        dcache_req = req; dcache_ready = rdy;
        #1;
        sm  = req && !rdy;
        lu  = emr && ((urs && rs == dest) || (urt && rt == dest));
        bub = !sm && (mis || mPend);
        st  = !sm && !bub && lu;
        pcw = !sm && !st;
        checkOutput("stall_mem", {15'd0, stall_mem}, {15'd0, sm});
        checkOutput("bubble", {15'd0, bubble}, {15'd0, bub});
        checkOutput("flush_if_id", {15'd0, flush_if_id}, {15'd0, bub});
        checkOutput("stall", {15'd0, stall}, {15'd0, st});
        checkOutput("pc_write", {15'd0, pc_write}, {15'd0, pcw});
        checkOutput("stall_cycles", stall_cycles, 16'(mCnt));
        checkOutput("mem_timeout", {15'd0, mem_timeout}, {15'd0, mTo});
        @(posedge clk);
        if (sm || bub || st) mCnt = (mCnt >= 65535) ? 65535 : mCnt + 1;
        if (bub) mPend = 1'b0;
        else if (mis && sm) mPend = 1'b1;
        mRun = sm ? mRun + 1 : 0;
        if (mRun >= TIMEOUT + 1) mTo = 1'b1;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        mPend = 1'b0; mCnt = 0; mRun = 0; mTo = 1'b0;
        @(negedge clk);
        doReset();

        // Reset mid-miss with a flush owed and 37 stall cycles counted.
        for (int i = 0; i < 34; i++)
            applyStimulus(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("pre_reset_count", stall_cycles, 16'd37);
        dcache_req = 1'b1;
        doReset();
        idleCycle();

        // Single load-use stall.
        applyStimulus(2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("loaduse_count", stall_cycles, 16'd1);
        doReset();

        // Mispredict during a three-cycle miss, replayed as one bubble.
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        idleCycle();
        checkOutput("miss_flush_count", stall_cycles, 16'd4);
        checkOutput("miss_flush_no_extra_bubble", {15'd0, bubble}, 16'd0);

        // Mispredict and load-use together.
        applyStimulus(2'd3, 2'd3, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        doReset();

        // Watchdog: sets on the fifth consecutive miss cycle, sticky afterwards.
        for (int i = 0; i < 4; i++)
            applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("watchdog_not_yet", {15'd0, mem_timeout}, 16'd0);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("watchdog_set", {15'd0, mem_timeout}, 16'd1);
        applyStimulus(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        idleCycle();
        checkOutput("watchdog_sticky", {15'd0, mem_timeout}, 16'd1);
        doReset();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            logic req, rdy;
            req = ($urandom_range(1) == 1);
            rdy = req && ($urandom_range(2) == 0);
            if ($urandom_range(199) == 0) doReset();
            applyStimulus(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 2'($urandom), $urandom_range(5) == 0, req, rdy);
        end

        // Saturation: run a continuous load-use stall to 16'hFFFE, then three more.
        doReset();
        id_rs = 2'd1; id_uses_rs = 1'b1; ex_mem_read = 1'b1; ex_dest = 2'd1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        mCnt = 65534;
        checkOutput("sat_preload", stall_cycles, 16'hFFFE);
        for (int i = 0; i < 3; i++)
            applyStimulus(2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_hold", stall_cycles, 16'hFFFF);
        idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
